if_branch_predictor: RTL and testbench

IF_BRANCH_PREDICTOR -- requirements
Module: if_branch_predictor

---
 rtl/if_branch_predictor.sv | 117 +++++++++++
 tb/tb_if_branch_predictor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if_branch_predictor.sv
// if_branch_predictor: direct-mapped BTB with 2-bit saturating counters and EX-stage misprediction redirect.
// Optional macro BP_UPDATE_BYPASS_EN forwards a same-cycle update to the lookup port. Rev 1.0
`default_nettype none

module if_branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        EX_rst_n,
  input  logic [31:0] IF_pc,
  input  logic        EX_IF_branch,
  input  logic        EX_IF_zero,
  input  logic [31:0] EX_IF_pc,
  input  logic [31:0] EX_IF_branch_target,
  input  logic [1:0]  EX_IF_predictor,
  input  logic [31:0] EX_IF_branch_target_predict,
  output logic        IF_predict_taken,
  output logic [1:0]  IF_predictor,
  output logic [31:0] IF_branch_target_predict,
  output logic        IF_redirect,
  output logic [31:0] IF_redirect_pc
);

  localparam int NUM_ENTRIES = 1 << INDEX_BITS;

  logic                valid_q  [NUM_ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [NUM_ENTRIES];
  logic [31:0]         target_q [NUM_ENTRIES];
  logic [1:0]          ctr_q    [NUM_ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [31:0]           br_pc;
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0]   up_tag;
  logic                  up_hit;
  logic                  up_we;
  logic [1:0]            ctr_old;
  logic [1:0]            ctr_d;
  logic [31:0]           target_d;
  logic                  bypass;
  logic                  lk_hit;
  logic [1:0]            lk_ctr;
  logic [31:0]           lk_target;
  logic                  unused_ok;

  assign lk_idx = IF_pc[2+INDEX_BITS-1:2];
  assign lk_tag = IF_pc[31:2+INDEX_BITS];

  // EX reports pc+4 of the branch; the table is keyed by the branch's own address.
  assign br_pc  = EX_IF_pc - 32'd4;
  assign up_idx = br_pc[2+INDEX_BITS-1:2];
  assign up_tag = br_pc[31:2+INDEX_BITS];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // A not-taken branch that is not already tracked leaves the table alone.
  assign up_we  = EX_IF_branch && (up_hit || EX_IF_zero);

  assign ctr_old = ctr_q[up_idx];

  always_comb begin
    ctr_d    = 2'b10;
    target_d = EX_IF_branch_target;
    if (up_hit) begin
      if (EX_IF_zero) begin
        ctr_d    = (ctr_old == 2'b11) ? 2'b11 : ctr_old + 2'b01;
        target_d = EX_IF_branch_target;
      end else begin
        ctr_d    = (ctr_old == 2'b00) ? 2'b00 : ctr_old - 2'b01;
        target_d = target_q[up_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge EX_rst_n) begin
    if (!EX_rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (up_we) begin
      valid_q[up_idx]  <= 1'b1;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= target_d;
      ctr_q[up_idx]    <= ctr_d;
    end
  end

`ifdef BP_UPDATE_BYPASS_EN
  assign bypass = up_we && (up_idx == lk_idx) && (up_tag == lk_tag);
`else
  assign bypass = 1'b0;
`endif

  assign lk_hit    = bypass || (valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag));
  assign lk_ctr    = bypass ? ctr_d    : ctr_q[lk_idx];
  assign lk_target = bypass ? target_d : target_q[lk_idx];

  assign IF_predict_taken         = lk_hit && lk_ctr[1];
  assign IF_predictor             = lk_hit ? lk_ctr : 2'b01;
  assign IF_branch_target_predict = IF_predict_taken ? lk_target : IF_pc + 32'd4;

  assign IF_redirect    = EX_IF_branch &&
                          (EX_IF_zero ? (EX_IF_branch_target_predict != EX_IF_branch_target)
                                      : (EX_IF_branch_target_predict != EX_IF_pc));
  assign IF_redirect_pc = !IF_redirect ? 32'd0 :
                          (EX_IF_zero ? EX_IF_branch_target : EX_IF_pc);

  // The fetch-time counter travels down the pipe for consistency checks only.
  assign unused_ok = ^{EX_IF_predictor, br_pc[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_if_branch_predictor.sv
// Directed bench for if_branch_predictor: reset, training, saturation, aliasing, wrap-around, reset discard.
`default_nettype none

module tb_if_branch_predictor;

  logic        clk = 1'b0;
  logic        EX_rst_n;
  logic [31:0] IF_pc;
  logic        EX_IF_branch;
  logic        EX_IF_zero;
  logic [31:0] EX_IF_pc;
  logic [31:0] EX_IF_branch_target;
  logic [1:0]  EX_IF_predictor;
  logic [31:0] EX_IF_branch_target_predict;
  logic        IF_predict_taken;
  logic [1:0]  IF_predictor;
  logic [31:0] IF_branch_target_predict;
  logic        IF_redirect;
  logic [31:0] IF_redirect_pc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_branch_predictor dut (
    .clk                         (clk),
    .EX_rst_n                    (EX_rst_n),
    .IF_pc                       (IF_pc),
    .EX_IF_branch                (EX_IF_branch),
    .EX_IF_zero                  (EX_IF_zero),
    .EX_IF_pc                    (EX_IF_pc),
    .EX_IF_branch_target         (EX_IF_branch_target),
    .EX_IF_predictor             (EX_IF_predictor),
    .EX_IF_branch_target_predict (EX_IF_branch_target_predict),
    .IF_predict_taken            (IF_predict_taken),
    .IF_predictor                (IF_predictor),
    .IF_branch_target_predict    (IF_branch_target_predict),
    .IF_redirect                 (IF_redirect),
    .IF_redirect_pc              (IF_redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic tk, input logic [1:0] ctr, input logic [31:0] tgt);
    chk({tag, ".taken"},  {31'd0, IF_predict_taken}, {31'd0, tk});
    chk({tag, ".ctr"},    {30'd0, IF_predictor},     {30'd0, ctr});
    chk({tag, ".target"}, IF_branch_target_predict,  tgt);
  endtask

  task automatic redir(input string tag, input logic r, input logic [31:0] pc);
    chk({tag, ".redirect"},    {31'd0, IF_redirect}, {31'd0, r});
    chk({tag, ".redirect_pc"}, IF_redirect_pc,       pc);
  endtask

  // Drives one EX update at the falling edge; it commits on the next rising edge.
  task automatic upd(input logic zero, input logic [31:0] pc4, input logic [31:0] tgt, input logic [31:0] tpred);
    @(negedge clk);
    EX_IF_branch                = 1'b1;
    EX_IF_zero                  = zero;
    EX_IF_pc                    = pc4;
    EX_IF_branch_target         = tgt;
    EX_IF_branch_target_predict = tpred;
  endtask

  task automatic idle(input logic [31:0] pc);
    @(negedge clk);
    EX_IF_branch = 1'b0;
    EX_IF_zero   = 1'b0;
    IF_pc        = pc;
  endtask

  initial begin
    logic [1:0] sat_exp [3];
    sat_exp = '{2'b11, 2'b11, 2'b11};

    EX_rst_n = 1'b0;
    IF_pc = 32'h40;
    EX_IF_branch = 1'b0;
    EX_IF_zero = 1'b0;
    EX_IF_pc = 32'h0;
    EX_IF_branch_target = 32'h0;
    EX_IF_predictor = 2'b01;
    EX_IF_branch_target_predict = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    EX_rst_n = 1'b1;
    #1;
    lookup("reset", 1'b0, 2'b01, 32'h44);
    redir("reset", 1'b0, 32'h0);

    // First taken branch at 0x40: allocate, mispredicted fall-through
    upd(1'b1, 32'h44, 32'h100, 32'h44);
    #1;
    redir("alloc", 1'b1, 32'h100);
`ifdef BP_UPDATE_BYPASS_EN
    lookup("same_cycle", 1'b1, 2'b10, 32'h100);
`else
    lookup("same_cycle", 1'b0, 2'b01, 32'h44);
`endif
    idle(32'h40);
    #1;
    lookup("trained", 1'b1, 2'b10, 32'h100);
    redir("idle", 1'b0, 32'h0);

    for (int i = 0; i < 3; i++) begin
      upd(1'b1, 32'h44, 32'h100, 32'h100);
      #1;
      redir("taken_ok", 1'b0, 32'h0);
      idle(32'h40);
      #1;
      chk("saturate.ctr", {30'd0, IF_predictor}, {30'd0, sat_exp[i]});
    end

    // Untracked not-taken branch at 0x80 (same index) must not disturb 0x40
    upd(1'b0, 32'h84, 32'h999, 32'h84);
    #1;
    redir("nt_miss", 1'b0, 32'h0);
    idle(32'h40);
    #1;
    lookup("nt_miss_keep", 1'b1, 2'b11, 32'h100);
    IF_pc = 32'h80;
    #1;
    lookup("nt_miss_noalloc", 1'b0, 2'b01, 32'h84);

    upd(1'b0, 32'h44, 32'h100, 32'h100);
    #1;
    redir("nt1", 1'b1, 32'h44);
    idle(32'h40);
    #1;
    lookup("nt1", 1'b1, 2'b10, 32'h100);
    upd(1'b0, 32'h44, 32'h100, 32'h100);
    idle(32'h40);
    #1;
    lookup("nt2", 1'b0, 2'b01, 32'h44);

    // Counter 01 -> 10 by taken, then mispredicted not-taken drops back to 01
    upd(1'b1, 32'h44, 32'h100, 32'h44);
    idle(32'h40);
    #1;
    chk("retrain.ctr", {30'd0, IF_predictor}, 32'd2);
    upd(1'b0, 32'h44, 32'h100, 32'h100);
    #1;
    redir("mispredict_nt", 1'b1, 32'h44);
    idle(32'h40);
    #1;
    lookup("mispredict_nt", 1'b0, 2'b01, 32'h44);

    upd(1'b1, 32'h444, 32'h200, 32'h444);
    #1;
    redir("alias", 1'b1, 32'h200);
    idle(32'h40);
    #1;
    lookup("alias_evicted", 1'b0, 2'b01, 32'h44);
    IF_pc = 32'h440;
    #1;
    lookup("alias_new", 1'b1, 2'b10, 32'h200);

    IF_pc = 32'hFFFF_FFFC;
    #1;
    lookup("wrap_miss", 1'b0, 2'b01, 32'h0);
    upd(1'b1, 32'h0, 32'h300, 32'h0);
    #1;
    redir("wrap", 1'b1, 32'h300);
    idle(32'hFFFF_FFFC);
    #1;
    lookup("wrap_hit", 1'b1, 2'b10, 32'h300);

    // Reset held across an update edge: table clears and the update is dropped
    upd(1'b1, 32'h48, 32'h500, 32'h48);
    EX_rst_n = 1'b0;
    IF_pc = 32'h440;
    #1;
    lookup("rst_async", 1'b0, 2'b01, 32'h444);
    @(posedge clk);
    idle(32'h44);
    EX_rst_n = 1'b1;
    #1;
    lookup("rst_discard", 1'b0, 2'b01, 32'h48);
    IF_pc = 32'hFFFF_FFFC;
    #1;
    lookup("rst_wrap", 1'b0, 2'b01, 32'h0);
    redir("rst_idle", 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
